instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Sequencer end of the CPU control interface. It owns the fetch/execute state bit, program counter (PC), instruction register (IR) and one-deep link register. It supplies state, opcode and eoe to the control decoder and consumes the decoder's PS, IL and MP to advance the PC. It also presents the instruction address to instruction memory and decoded IR fields to the datapath.

Parameters:
PC_WIDTH, 8, width of PC, link register and instruction address
IW, 16, instruction width (fixed layout below; must be 16)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  fetch enable; FETCH stalls while low
imem_data  in  IW  instruction word at imem_addr (combinational read)
PS  in  2  PC select from decoder: 00 hold, 01 increment, 10 branch, 11 return
IL  in  1  instruction load
MP  in  1  call: save return address, jump
imem_addr  out  PC_WIDTH  equals pc
pc  out  PC_WIDTH  current PC
state  out  1  0 = FETCH, 1 = EXECUTE (to decoder)
opcode  out  4  IR[15:12]
eoe  out  4  IR[11:8]
dr  out  4  IR[11:8] (destination register)
sa  out  4  IR[7:4]
sb  out  4  IR[3:0]
imm  out  IW  IR[3:0] zero-extended
offset  out  PC_WIDTH  IR[7:0] sign-extended or truncated to PC_WIDTH
link_pc  out  PC_WIDTH  link register value (write-back data when MP=1)
halted  out  1  end of execution reached

Behaviour:
- Reset (async, any time, including mid-instruction): state=FETCH, pc=0, IR=0, link=0, halted=0. All outputs are derived from these registers, so every output is 0 during reset.
- All registers update on rising clk only. Decoder-facing outputs are registered or pure functions of registers, so there is no combinational path from PS/IL/MP to state/opcode/eoe.
- FETCH (state=0):
  - If run=1 and IL=1: IR <= imem_data, state <= EXECUTE.
  - If run=0 or IL=0: IR and state hold.
  - PC never changes in FETCH.
- EXECUTE (state=1): state <= FETCH. Next PC, all arithmetic modulo 2^PC_WIDTH:
  - MP=1 (priority over PS): link <= pc+1, pc <= pc+offset.
  - PS=01: pc <= pc+1.
  - PS=10: pc <= pc+offset. Offset is relative to the branch instruction's own address.
  - PS=11: pc <= link; link unchanged.
  - PS=00: pc holds.
- Halt: in EXECUTE with opcode=4'hF and eoe=4'hF, halted <= 1 and the state machine freezes in FETCH with IL ignored. Only rst clears halted.
- IR is loaded only in FETCH; IL=1 during EXECUTE is ignored.
- The link register is one deep. A second call overwrites it; a return without a prior call restores 0.
- Wrap: pc = 2^PC_WIDTH-1 with increment gives 0. A negative offset below 0 wraps modulo 2^PC_WIDTH.
- Throughput: one instruction per 2 cycles while run=1.

Decomposition:
- Package cpu_pkg holds:
  - PS codes: PS_HOLD=2'b00, PS_INC=2'b01, PS_BR=2'b10, PS_RET=2'b11.
  - State encoding: ST_FETCH=0, ST_EXEC=1.
  - Opcode constants: OP_LDI=4'h8 through OP_EOE=4'hF.
  - EOE_HALT=4'hF.
  - IR field bit positions.
- Sub-module pc_next_mux: combinational next-PC and link-enable selection from pc, offset, link, PS, MP. The registers stay in instr_sequencer.

Test Plan:
- Reset then run=1, IL=1 in FETCH, imem[0]=16'h0123, PS=01 in EXECUTE -> IR=16'h0123, opcode=0, state toggles 0,1,0, pc=1 after 2 cycles.
- Branch at pc=5 with IR[7:0]=8'hFD, PS=10 -> pc=2. With IR[7:0]=8'h03 and PC_WIDTH=8 at pc=8'hFE -> pc=8'h01 (wrap).
- Call at pc=10 with MP=1, PS=01, offset=6 -> pc=16, link_pc=11. Later EXECUTE with PS=11 -> pc=11.
- IR=16'hFF00 in EXECUTE -> halted=1 next edge, state=FETCH. Further IL/run pulses leave pc and IR unchanged for 10 cycles.
- run=0 for 3 cycles in FETCH -> state, pc, IR stable. Raising run resumes fetch on the next edge.
- Assert rst asynchronously mid-EXECUTE, between edges, with pc=7 -> pc, state, IR, link_pc and halted all read 0 before the next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the CPU control interface
package cpu_pkg;
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_RET  = 2'b11;
  localparam logic ST_FETCH = 1'b0;
  localparam logic ST_EXEC  = 1'b1;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_EOE  = 4'hF;
  localparam logic [3:0] EOE_HALT = 4'hF;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DR_HI  = 11;
  localparam int DR_LO  = 8;
  localparam int SA_HI  = 7;
  localparam int SA_LO  = 4;
  localparam int SB_HI  = 3;
  localparam int SB_LO  = 0;
  localparam int OFS_HI = 7;
  localparam int OFS_LO = 0;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC and link-write selection for the EXECUTE step
module pc_next_mux import cpu_pkg::*; #(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [PC_WIDTH-1:0] offset_i,
  input  logic [PC_WIDTH-1:0] link_i,
  input  logic [1:0]          ps_i,
  input  logic                mp_i,
  output logic [PC_WIDTH-1:0] pc_next_o,
  output logic [PC_WIDTH-1:0] link_next_o,
  output logic                link_we_o
);
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_rel;
  assign pc_inc = pc_i + PC_WIDTH'(1);
  assign pc_rel = pc_i + offset_i;
  assign link_next_o = pc_inc;
  assign link_we_o = mp_i;
  // a call jumps relative regardless of PS; otherwise PS picks the source
  always_comb
    pc_next_o = (mp_i || ps_i == PS_BR) ? pc_rel :
                (ps_i == PS_INC)        ? pc_inc :
                (ps_i == PS_RET)        ? link_i : pc_i;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute state, PC, IR and link register for the CPU
module instr_sequencer import cpu_pkg::*; #(
  parameter int PC_WIDTH = 8,
  parameter int IW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [IW-1:0]       imem_data,
  input  logic [1:0]          PS,
  input  logic                IL,
  input  logic                MP,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                state,
  output logic [3:0]          opcode,
  output logic [3:0]          eoe,
  output logic [3:0]          dr,
  output logic [3:0]          sa,
  output logic [3:0]          sb,
  output logic [IW-1:0]       imm,
  output logic [PC_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0] link_pc,
  output logic                halted
);
  logic                state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, link_q, link_d, pc_nx, link_nx;
  logic [IW-1:0]       ir_q, ir_d;
  logic                halted_q, halted_d, link_we, fetch_go, exec;
  assign exec     = state_q == ST_EXEC;
  assign fetch_go = state_q == ST_FETCH && run && IL && !halted_q;
  assign opcode   = ir_q[OPC_HI:OPC_LO];
  assign eoe      = ir_q[DR_HI:DR_LO];
  assign dr       = ir_q[DR_HI:DR_LO];
  assign sa       = ir_q[SA_HI:SA_LO];
  assign sb       = ir_q[SB_HI:SB_LO];
  assign imm      = IW'(ir_q[SB_HI:SB_LO]);
  assign offset   = PC_WIDTH'($signed(ir_q[OFS_HI:OFS_LO]));
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign state     = state_q;
  assign link_pc   = link_q;
  assign halted    = halted_q;
  pc_next_mux #(.PC_WIDTH(PC_WIDTH)) u_mux (
    .pc_i(pc_q), .offset_i(offset), .link_i(link_q), .ps_i(PS), .mp_i(MP),
    .pc_next_o(pc_nx), .link_next_o(link_nx), .link_we_o(link_we)
  );
  // EXECUTE always returns to FETCH; FETCH advances only on a load while not halted
  always_comb begin
    state_d  = fetch_go ? ST_EXEC : ST_FETCH;
    ir_d     = fetch_go ? imem_data : ir_q;
    pc_d     = exec ? pc_nx : pc_q;
    link_d   = (exec && link_we) ? link_nx : link_q;
    halted_d = halted_q || (exec && opcode == OP_EOE && eoe == EOE_HALT);
  end
  // sequencer registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      link_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      link_q   <= link_d;
      halted_q <= halted_d;
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed checks against a behavioural model
module tb_instr_sequencer;
  localparam int PW = 8;
  localparam int IW = 16;
  logic clk = 0, rst = 0, run = 0, IL = 0, MP = 0;
  logic [1:0] PS = 0;
  logic [IW-1:0] imem_data, imm;
  logic [PW-1:0] imem_addr, pc, offset, link_pc;
  logic state, halted;
  logic [3:0] opcode, eoe, dr, sa, sb;
  logic [15:0] mem [256];
  int total = 0, bad = 0;
  int m_pc, m_link, m_state, m_halted;
  logic [15:0] m_ir;

  instr_sequencer #(.PC_WIDTH(PW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_data(imem_data), .PS(PS), .IL(IL), .MP(MP),
    .imem_addr(imem_addr), .pc(pc), .state(state), .opcode(opcode), .eoe(eoe), .dr(dr),
    .sa(sa), .sb(sb), .imm(imm), .offset(offset), .link_pc(link_pc), .halted(halted)
  );

  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;

  function automatic logic [69:0] act();
    return {pc, state, opcode, eoe, dr, sa, sb, imm, offset, link_pc, halted, imem_addr};
  endfunction

  function automatic logic [69:0] expv();
    logic [7:0] p, l;
    p = m_pc[7:0];
    l = m_link[7:0];
    return {p, m_state[0], m_ir[15:12], m_ir[11:8], m_ir[11:8], m_ir[7:4], m_ir[3:0],
            {12'h000, m_ir[3:0]}, m_ir[7:0], l, m_halted[0], p};
  endfunction

  task automatic model_rst();
    m_pc = 0; m_link = 0; m_state = 0; m_halted = 0; m_ir = 16'h0;
  endtask

  task automatic model_step(input bit r, input bit il, input int ps, input bit mp);
    int off;
    off = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
    if (m_state == 0) begin
      if (!m_halted && r && il) begin
        m_ir = mem[m_pc];
        m_state = 1;
      end
    end else begin
      m_state = 0;
      if (mp) begin
        m_link = (m_pc + 1) % 256;
        m_pc = (m_pc + off) & 255;
      end else if (ps == 1) m_pc = (m_pc + 1) % 256;
      else if (ps == 2) m_pc = (m_pc + off) & 255;
      else if (ps == 3) m_pc = m_link;
      if (m_ir[15:8] == 8'hFF) m_halted = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit il, input int ps, input bit mp);
    run = r; IL = il; PS = ps[1:0]; MP = mp;
    model_step(r, il, ps, mp);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    run = 0; IL = 0; PS = 0; MP = 0;
    rst = 1;
    model_rst();
    #2 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    model_rst();
    #1;
    total++; if (act() !== 70'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", act()); end
    @(negedge clk); #2 rst = 0;
    @(posedge clk); #1;
    total++; if (act() !== expv()) begin bad++; $display("FAIL reset_idle: got %h want %h", act(), expv()); end
  endtask

  task automatic test_fetch_inc();
    mem[0] = 16'h0123;
    cyc(1, 1, 0, 0);
    total++; if (act() !== expv() || state !== 1'b1 || opcode !== 4'h0 || {eoe, sa, sb} !== 12'h123)
      begin bad++; $display("FAIL fetch_load: got %h want %h", act(), expv()); end
    cyc(1, 0, 1, 0);
    total++; if (act() !== expv() || pc !== 8'd1 || state !== 1'b0)
      begin bad++; $display("FAIL fetch_inc: got %h want %h", act(), expv()); end
  endtask

  task automatic test_branch();
    apply_reset();
    mem[0] = 16'h0005; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    total++; if (pc !== 8'd5 || act() !== expv()) begin bad++; $display("FAIL br_fwd: got pc=%0d want 5", pc); end
    mem[5] = 16'h00FD; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    total++; if (pc !== 8'd2 || act() !== expv()) begin bad++; $display("FAIL br_back: got pc=%0d want 2", pc); end
    mem[2] = 16'h00FC; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    total++; if (pc !== 8'hFE || act() !== expv()) begin bad++; $display("FAIL br_underflow: got pc=%h want fe", pc); end
    mem[8'hFE] = 16'h0003; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    total++; if (pc !== 8'h01 || act() !== expv()) begin bad++; $display("FAIL br_wrap: got pc=%h want 01", pc); end
  endtask

  task automatic test_call_ret();
    mem[1] = 16'h0009; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    total++; if (pc !== 8'd10) begin bad++; $display("FAIL call_setup: got pc=%0d want 10", pc); end
    mem[10] = 16'h0006; cyc(1, 1, 0, 0); cyc(1, 0, 1, 1);
    total++; if (pc !== 8'd16 || link_pc !== 8'd11 || act() !== expv())
      begin bad++; $display("FAIL call: got pc=%0d link=%0d want 16/11", pc, link_pc); end
    mem[16] = 16'h0000; cyc(1, 1, 0, 0); cyc(1, 0, 3, 0);
    total++; if (pc !== 8'd11 || link_pc !== 8'd11 || act() !== expv())
      begin bad++; $display("FAIL ret: got pc=%0d link=%0d want 11/11", pc, link_pc); end
  endtask

  task automatic test_run_stall();
    mem[11] = 16'h2345;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1);
      total++; if (act() !== expv() || pc !== 8'd11 || state !== 1'b0 || opcode !== 4'h0)
        begin bad++; $display("FAIL stall%0d: got %h want %h", i, act(), expv()); end
    end
    cyc(1, 1, 0, 0);
    total++; if (state !== 1'b1 || opcode !== 4'h2 || sb !== 4'h5 || act() !== expv())
      begin bad++; $display("FAIL resume: got %h want %h", act(), expv()); end
    cyc(1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      do w = 16'($urandom); while (w[15:8] == 8'hFF);
      mem[i] = w;
    end
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 4) == 0);
      total++; if (act() !== expv()) begin bad++; $display("FAIL random%0d: got %h want %h", i, act(), expv()); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    mem[0] = 16'h0007; cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    mem[7] = 16'h1234; cyc(1, 1, 0, 0);
    total++; if (pc !== 8'd7 || state !== 1'b1) begin bad++; $display("FAIL arst_setup: got pc=%0d st=%b want 7/1", pc, state); end
    PS = 2'b01; MP = 1'b1;
    #2 rst = 1;
    model_rst();
    #1;
    total++; if (act() !== 70'h0 || act() !== expv()) begin bad++; $display("FAIL arst_mid: got %h want 0", act()); end
    run = 0; IL = 0; PS = 0; MP = 0;
    #1 rst = 0;
    @(posedge clk); #1;
    total++; if (act() !== expv()) begin bad++; $display("FAIL arst_after: got %h want %h", act(), expv()); end
  endtask

  task automatic test_halt();
    logic [7:0] hp;
    apply_reset();
    mem[0] = 16'h0003; mem[3] = 16'hFF00;
    cyc(1, 1, 0, 0); cyc(1, 0, 2, 0);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    total++; if (halted !== 1'b1 || state !== 1'b0 || act() !== expv())
      begin bad++; $display("FAIL halt: got %h want %h", act(), expv()); end
    hp = pc;
    for (int i = 0; i < 10; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
      total++; if (act() !== expv() || pc !== hp || {opcode, eoe, sa, sb} !== 16'hFF00 || state !== 1'b0)
        begin bad++; $display("FAIL halt_frozen%0d: got %h want %h", i, act(), expv()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    model_rst();
    test_reset();
    test_fetch_inc();
    test_branch();
    test_call_ret();
    test_run_stall();
    test_random();
    test_async_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
